// File: rtl/bht_update_ctrl.sv
// Branch history table controller: clear sweep after reset/flush, one lookup per cycle,
// and an update queue that drains one resolved branch per cycle into the table.
module bht_update_ctrl #(
   parameter int unsigned M      = 16,
   parameter int unsigned N      = 1,
   parameter int unsigned QDEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       lookup_valid_i,
   input  logic [8:0]                 lookup_pc_i,
   output logic                       pred_valid_o,
   output logic                       pred_taken_o,
   input  logic                       upd_valid_i,
   input  logic [8:0]                 upd_pc_i,
   input  logic                       upd_taken_i,
   output logic                       upd_ready_o,
   output logic                       init_busy_o,
   output logic [$clog2(QDEPTH):0]    q_count_o
);

   localparam int unsigned IdxW  = $clog2(M);
   localparam int unsigned QPtrW = $clog2(QDEPTH);
   localparam int unsigned CntW  = QPtrW + 1;

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e               state_q, state_d;
   logic [IdxW-1:0]      clr_idx_q, clr_idx_d;

   logic [N-1:0]         table_q [M];
   logic [IdxW-1:0]      q_idx_q [QDEPTH];
   logic                 q_tkn_q [QDEPTH];
   logic [QPtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [QPtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;

   logic                 pred_valid_q, pred_taken_q, pred_taken_d;
   logic                 in_run, push, pop;
   logic [IdxW-1:0]      lk_idx, upd_idx, head_idx;
   logic                 head_tkn;
   logic [N-1:0]         head_cur, head_new, lk_val;
   logic                 unused_pc;

   assign lk_idx    = lookup_pc_i[IdxW-1:0];
   assign upd_idx   = upd_pc_i[IdxW-1:0];
   assign unused_pc = ^{lookup_pc_i, upd_pc_i};

   // FSM: state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StInit;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (flush_i) begin
         state_d   = StInit;
         clr_idx_d = '0;
      end else begin
         unique case (state_q)
            StInit: begin
               clr_idx_d = clr_idx_q + 1'b1;
               if (clr_idx_q == IdxW'(M - 1)) state_d = StRun;
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
         endcase
      end
   end

   // FSM: outputs and queue handshake
   always_comb begin
      in_run      = (state_q == StRun);
      init_busy_o = (state_q == StInit);
      upd_ready_o = in_run && (cnt_q < CntW'(QDEPTH)) && !flush_i;
      push        = upd_valid_i && upd_ready_o;
      pop         = in_run && (cnt_q != '0) && !flush_i;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      end
   end

   // Saturating counter update; with N=1 this degenerates to "store the outcome".
   always_comb begin
      head_idx = q_idx_q[rd_ptr_q];
      head_tkn = q_tkn_q[rd_ptr_q];
      head_cur = table_q[head_idx];
      if (head_tkn) begin
         head_new = (&head_cur) ? head_cur : head_cur + N'(1);
      end else begin
         head_new = (head_cur == '0) ? head_cur : head_cur - N'(1);
      end
   end

   // Forward a same-cycle write so the lookup sees the post-update counter.
   always_comb begin
      lk_val       = (pop && (head_idx == lk_idx)) ? head_new : table_q[lk_idx];
      pred_taken_d = lookup_valid_i && in_run && lk_val[N-1];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
      end else begin
         pred_valid_q <= lookup_valid_i;
         pred_taken_q <= pred_taken_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
      end
   end

   // Table and queue storage carry no reset; the INIT sweep defines table contents.
   always_ff @(posedge clk_i) begin
      if (init_busy_o) begin
         table_q[clr_idx_q] <= '0;
      end else if (pop) begin
         table_q[head_idx] <= head_new;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         q_idx_q[wr_ptr_q] <= upd_idx;
         q_tkn_q[wr_ptr_q] <= upd_taken_i;
      end
   end

   assign pred_valid_o = pred_valid_q;
   assign pred_taken_o = pred_taken_q;
   assign q_count_o    = cnt_q;

   a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q <= CntW'(QDEPTH));
   a_no_push_in_init: assert property (@(posedge clk_i) disable iff (!rst_ni)
      init_busy_o |-> !push && !pop);

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Bench for bht_update_ctrl: N=1 and N=2 instances share random stimulus and are
// compared each cycle against a transaction-level table/queue model.
module tb_bht_update_ctrl;

   localparam int unsigned M      = 16;
   localparam int unsigned QDEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush, lookup_valid, upd_valid, upd_taken;
   logic [8:0] lookup_pc, upd_pc;

   logic       pv1, pt1, rdy1, busy1;
   logic       pv2, pt2, rdy2, busy2;
   logic [2:0] qc1, qc2;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int  init_left;
   int  tbl1 [M];
   int  tbl2 [M];
   int  q_idx [$];
   bit  q_tkn [$];
   bit  exp_pv, exp_pt1, exp_pt2, exp_pt_known;

   always #5 clk = ~clk;

   bht_update_ctrl #(.M(M), .N(1), .QDEPTH(QDEPTH)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .lookup_valid_i(lookup_valid), .lookup_pc_i(lookup_pc),
      .pred_valid_o(pv1), .pred_taken_o(pt1),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .upd_ready_o(rdy1), .init_busy_o(busy1), .q_count_o(qc1)
   );

   bht_update_ctrl #(.M(M), .N(2), .QDEPTH(QDEPTH)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .lookup_valid_i(lookup_valid), .lookup_pc_i(lookup_pc),
      .pred_valid_o(pv2), .pred_taken_o(pt2),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .upd_ready_o(rdy2), .init_busy_o(busy2), .q_count_o(qc2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      init_left = M;
      q_idx.delete();
      q_tkn.delete();
      for (int i = 0; i < M; i++) begin
         tbl1[i] = 0;
         tbl2[i] = 0;
      end
      exp_pv       = 1'b0;
      exp_pt1      = 1'b0;
      exp_pt2      = 1'b0;
      exp_pt_known = 1'b1;
   endfunction

   function automatic int sat2(input int v, input bit t);
      if (t) return (v == 3) ? 3 : v + 1;
      return (v == 0) ? 0 : v - 1;
   endfunction

   function automatic bit model_ready(input bit fl);
      return (init_left == 0) && (q_idx.size() < QDEPTH) && !fl;
   endfunction

   // One clock edge of the reference model
   function automatic void model_step(input bit fl, input bit lv, input logic [8:0] lpc,
                                      input bit uv, input logic [8:0] upc, input bit ut);
      int li = int'(lpc) % M;
      bit rdy = model_ready(fl);
      exp_pv       = lv;
      exp_pt_known = 1'b1;
      if (fl) begin
         exp_pt_known = 1'b0;
         q_idx.delete();
         q_tkn.delete();
         for (int i = 0; i < M; i++) begin
            tbl1[i] = 0;
            tbl2[i] = 0;
         end
         init_left = M;
      end else if (init_left > 0) begin
         exp_pt1 = 1'b0;
         exp_pt2 = 1'b0;
         init_left--;
      end else begin
         if (q_idx.size() > 0) begin
            int hi = q_idx.pop_front();
            bit ht = q_tkn.pop_front();
            tbl1[hi] = int'(ht);
            tbl2[hi] = sat2(tbl2[hi], ht);
         end
         exp_pt1 = (tbl1[li] != 0);
         exp_pt2 = (tbl2[li] >= 2);
         if (uv && rdy) begin
            q_idx.push_back(int'(upc) % M);
            q_tkn.push_back(ut);
         end
      end
   endfunction

   task automatic check_outputs();
      check_eq("pred_valid_n1", pv1, int'(exp_pv));
      check_eq("pred_valid_n2", pv2, int'(exp_pv));
      if (exp_pv && exp_pt_known) begin
         check_eq("pred_taken_n1", pt1, int'(exp_pt1));
         check_eq("pred_taken_n2", pt2, int'(exp_pt2));
      end
      check_eq("init_busy_n1", busy1, int'(init_left > 0));
      check_eq("init_busy_n2", busy2, int'(init_left > 0));
      check_eq("q_count_n1", qc1, q_idx.size());
      check_eq("q_count_n2", qc2, q_idx.size());
   endtask

   // Called just after a falling edge: check, drive, then advance the model for the next edge
   task automatic apply(input bit fl, input bit lv, input logic [8:0] lpc,
                        input bit uv, input logic [8:0] upc, input bit ut);
      check_outputs();
      flush = fl; lookup_valid = lv; lookup_pc = lpc;
      upd_valid = uv; upd_pc = upc; upd_taken = ut;
      #1;
      check_eq("upd_ready_n1", rdy1, int'(model_ready(fl)));
      check_eq("upd_ready_n2", rdy2, int'(model_ready(fl)));
      model_step(fl, lv, lpc, uv, upc, ut);
   endtask

   task automatic drive_cycle(input bit fl, input bit lv, input logic [8:0] lpc,
                              input bit uv, input logic [8:0] upc, input bit ut);
      @(negedge clk);
      apply(fl, lv, lpc, uv, upc, ut);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      flush = 0; lookup_valid = 0; lookup_pc = '0;
      upd_valid = 0; upd_pc = '0; upd_taken = 0;
      #1;
      model_reset();
      check_eq("rst_pred_valid", pv1 | pv2, 0);
      check_eq("rst_pred_taken", pt1 | pt2, 0);
      check_eq("rst_init_busy", busy1 & busy2, 1);
      check_eq("rst_q_count", qc1 | qc2, 0);
      check_eq("rst_upd_ready", rdy1 | rdy2, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      apply(0, 0, '0, 0, '0, 0);
   endtask

   function automatic logic [8:0] rand_pc();
      logic [8:0] p = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) p[3:0] = 4'($urandom_range(0, 3));
      return p;
   endfunction

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, 0, '0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      flush = 0; lookup_valid = 0; lookup_pc = '0;
      upd_valid = 0; upd_pc = '0; upd_taken = 0;
      model_reset();

      // Sweep after reset: lookups and offered updates during INIT
      do_reset();
      for (int i = 0; i < 20; i++) drive_cycle(0, 1, rand_pc(), 1, rand_pc(), 1);

      // Aliased same-cycle pop/lookup on a freshly cleared table
      do_reset();
      idle_cycles(16);
      drive_cycle(0, 0, '0, 1, 9'h013, 1);
      drive_cycle(0, 1, 9'h003, 0, '0, 0);
      @(posedge clk); #1;
      check_eq("fwd_alias_n1", pt1, 1);
      check_eq("fwd_alias_n2", pt2, 0);

      // Counter training on pc 0x005
      drive_cycle(0, 1, 9'h005, 1, 9'h005, 1);
      drive_cycle(0, 1, 9'h005, 1, 9'h005, 1);
      drive_cycle(0, 1, 9'h005, 1, 9'h005, 1);
      @(posedge clk); #1;
      check_eq("train_taken_n2", pt2, 1);
      drive_cycle(0, 1, 9'h005, 1, 9'h005, 0);
      drive_cycle(0, 1, 9'h005, 1, 9'h005, 0);
      drive_cycle(0, 1, 9'h105, 0, '0, 0);
      @(posedge clk); #1;
      check_eq("train_back_n2", pt2, 0);
      check_eq("train_back_n1", pt1, 0);

      // Flush with a pending update, then confirm trained entries are cleared
      for (int i = 0; i < 40; i++) drive_cycle(0, 1, rand_pc(), 1, rand_pc(), 1);
      drive_cycle(0, 0, '0, 1, 9'h007, 1);
      drive_cycle(1, 0, '0, 1, 9'h007, 1);
      idle_cycles(17);
      for (int i = 0; i < M; i++) drive_cycle(0, 1, 9'(i), 0, '0, 0);

      // Reset mid-INIT and with an update queued
      do_reset();
      idle_cycles(7);
      do_reset();
      idle_cycles(20);
      drive_cycle(0, 0, '0, 1, 9'h00a, 1);
      do_reset();
      for (int i = 0; i < 20; i++) drive_cycle(0, 1, rand_pc(), 0, '0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 999) begin
            do_reset();
         end else begin
            drive_cycle($urandom_range(0, 99) == 0, 1'($urandom), rand_pc(),
                        $urandom_range(0, 3) != 0, rand_pc(), 1'($urandom));
         end
      end
      @(negedge clk);
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
